piso_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly upstream of the 4-bit serial shift register and drives its serial input bit stream. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, optionally followed by an even-parity bit. Back-to-back words stream with no idle cycle between frames, so the downstream register sees a continuous stream.

---
 rtl/piso_serializer_pkg.sv | 15 +
 rtl/piso_serializer.sv | 77 +++++++
 tb/tb_piso_serializer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// The frame-length helper is also used by verification scoreboards.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits per frame: data bits plus an optional even-parity bit.
  function automatic int frame_len(input int width, input int parity);
    return width + ((parity != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serializes WIDTH-bit words one bit per clock with an optional trailing
// even-parity bit; back-to-back words stream with no idle gap.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int L  = frame_len(WIDTH, PARITY);
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic             par;
  logic             accept;
  logic             is_par;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake and frame markers come from registered state only.
  always_comb begin
    state_nxt = state;
    x_valid_o = (state == SHIFT);
    last_o    = x_valid_o && (count == CW'(L - 1));
    first_o   = x_valid_o && (count == '0);
    ready_o   = (state == IDLE) || last_o;
    busy_o    = x_valid_o;
    accept    = valid_i && ready_o;
    is_par    = (PARITY != 0) && (count == CW'(WIDTH));
    x_o       = 1'b0;
    if (x_valid_o) begin
      if (is_par)              x_o = par;
      else if (MSB_FIRST != 0) x_o = shreg[WIDTH-1];
      else                     x_o = shreg[0];
    end
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (last_o) state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outgoing bit always sits at the emitting end of the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else if (accept) begin
      count <= '0;
      shreg <= data_i;
      par   <= ^data_i;
    end else if (state == SHIFT) begin
      count <= last_o ? '0 : count + CW'(1);
      if (MSB_FIRST != 0) shreg <= {shreg[WIDTH-2:0], 1'b0};
      else                shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Drives two serializer configurations with directed then random words and
// checks every output against a queue-of-frame-bits reference model.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  typedef struct {
    logic b;
    logic f;
    logic l;
  } ebit_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_i = 1'b0;
  logic [3:0] data_i = 4'h0;

  logic rdy0, x0, xv0, f0, l0, bz0;
  logic rdy1, x1, xv1, f1, l1, bz1;

  int n_cmp = 0;
  int n_err = 0;

  ebit_t q0[$];
  ebit_t q1[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .PARITY(0)) dut0 (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
    .ready_o(rdy0), .x_o(x0), .x_valid_o(xv0), .first_o(f0),
    .last_o(l0), .busy_o(bz0)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .PARITY(1)) dut1 (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
    .ready_o(rdy1), .x_o(x1), .x_valid_o(xv1), .first_o(f1),
    .last_o(l1), .busy_o(bz1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // A frame is the list of bits the spec says to emit, in emission order.
  function automatic void push_frame(input int which, input logic [3:0] d,
                                     input bit msb, input bit par);
    int len;
    ebit_t e;
    len = frame_len(4, par ? 1 : 0);
    for (int k = 0; k < len; k++) begin
      e.b = (k < 4) ? (msb ? d[3-k] : d[k]) : ^d;
      e.f = (k == 0);
      e.l = (k == len - 1);
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
  endfunction

  task automatic check_outputs();
    ebit_t e;
    if (q0.size() > 0) begin
      e = q0[0];
      chk("d0.x_o", x0, e.b); chk("d0.x_valid", xv0, 1'b1);
      chk("d0.first", f0, e.f); chk("d0.last", l0, e.l);
    end else begin
      chk("d0.x_o", x0, 1'b0); chk("d0.x_valid", xv0, 1'b0);
      chk("d0.first", f0, 1'b0); chk("d0.last", l0, 1'b0);
    end
    chk("d0.busy", bz0, q0.size() > 0);
    chk("d0.ready", rdy0, q0.size() <= 1);
    if (q1.size() > 0) begin
      e = q1[0];
      chk("d1.x_o", x1, e.b); chk("d1.x_valid", xv1, 1'b1);
      chk("d1.first", f1, e.f); chk("d1.last", l1, e.l);
    end else begin
      chk("d1.x_o", x1, 1'b0); chk("d1.x_valid", xv1, 1'b0);
      chk("d1.first", f1, 1'b0); chk("d1.last", l1, 1'b0);
    end
    chk("d1.busy", bz1, q1.size() > 0);
    chk("d1.ready", rdy1, q1.size() <= 1);
  endtask

  // One clock: apply inputs, advance the model across the edge, check.
  task automatic step(input logic rst, input logic v, input logic [3:0] d);
    bit acc0, acc1;
    reset   = rst;
    valid_i = v;
    data_i  = d;
    acc0 = v && (q0.size() <= 1);
    acc1 = v && (q1.size() <= 1);
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc0) push_frame(0, d, 1'b1, 1'b0);
      if (acc1) push_frame(1, d, 1'b0, 1'b1);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    // reset held with valid high: nothing may start
    step(1'b1, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);
    // single word
    step(1'b0, 1'b1, 4'b1011);
    repeat (6) step(1'b0, 1'b0, 4'b0000);
    // back-to-back
    step(1'b0, 1'b1, 4'b1011);
    repeat (4) step(1'b0, 1'b1, 4'b0110);
    repeat (7) step(1'b0, 1'b0, 4'b1111);
    // reset mid-frame, then a clean word
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 4'b1110);
    step(1'b0, 1'b1, 4'b0001);
    repeat (6) step(1'b0, 1'b0, 4'b0000);
    // upstream stall between words
    step(1'b0, 1'b1, 4'b0101);
    repeat (8) step(1'b0, 1'b0, 4'b1010);
    step(1'b0, 1'b1, 4'b1100);
    repeat (6) step(1'b0, 1'b0, 4'b0000);
    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           4'($urandom_range(0, 15)));
    end
    repeat (6) step(1'b0, 1'b0, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
